uart_rx: RTL and testbench

UART receive PHY, the counterpart of the transmit PHY.
- Synchronises the asynchronous rx line and detects start bits using an oversampled baud tick.
- Samples 5-9 data bits (LSB first), an optional parity bit and one stop bit.
- Presents each frame in a one-entry holding register, with a vld/rdy handshake to the UART core and per-frame error flags.

---
 rtl/uart_rx.sv | 213 +++++++++++++++++++++
 tb/tb_uart_rx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// UART receive PHY: synchronises rx, finds start bits on an oversampled baud
// tick, shifts in 5-9 data bits LSB first plus optional parity and one stop
// bit, and hands each frame to the core through a one-entry vld/rdy holding
// register with per-frame parity and framing error flags.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_W     = 9
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              baud_tick,
  input  logic              rx,
  input  logic [3:0]        cfg_nbits,
  input  logic              cfg_parity_en,
  input  logic              cfg_parity_odd,
  input  logic              rdy,
  output logic              vld,
  output logic [DATA_W-1:0] data,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CNT_W    = $clog2(OVERSAMPLE);
  localparam int MAX_BITS = (DATA_W < 9) ? DATA_W : 9;

  localparam logic [CNT_W-1:0] MID_START = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_BIT  = CNT_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  state_e            state_q, state_d;
  logic              rx_meta_q, rs_q;
  logic [CNT_W-1:0]  tick_cnt_q, tick_cnt_d;
  logic [3:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [3:0]        nbits_q, nbits_d;
  logic              par_en_q, par_en_d;
  logic              par_odd_q, par_odd_d;
  logic              frame_perr_q, frame_perr_d;
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              parity_err_q, parity_err_d;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q, overrun_d;
  logic [3:0]        nbits_clamped;

  // Two-flop synchroniser; reset to the idle-high line level so reset
  // release never looks like a start bit.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    if (!reset_n) begin
      rx_meta_q <= 1'b1;
      rs_q      <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rs_q      <= rx_meta_q;
    end
  end

  // Clamp the requested frame length into the supported range.
  always_comb begin
    nbits_clamped = cfg_nbits;
    if (cfg_nbits < 4'd5) begin
      nbits_clamped = 4'd5;
    end else if (cfg_nbits > 4'(MAX_BITS)) begin
      nbits_clamped = 4'(MAX_BITS);
    end
  end

  // Next-state logic for the frame FSM and the holding register.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    nbits_d      = nbits_q;
    par_en_d     = par_en_q;
    par_odd_d    = par_odd_q;
    frame_perr_d = frame_perr_q;
    vld_d        = vld_q;
    data_d       = data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;

    // Consumer takes the held frame; a load below in the same cycle wins.
    if (vld_q && rdy) begin
      vld_d = 1'b0;
    end

    if (baud_tick) begin
      unique case (state_q)
        IDLE: begin
          if (!rs_q) begin
            state_d      = START;
            tick_cnt_d   = '0;
            bit_cnt_d    = '0;
            shift_d      = '0;
            frame_perr_d = 1'b0;
            nbits_d      = nbits_clamped;
            par_en_d     = cfg_parity_en;
            par_odd_d    = cfg_parity_odd;
          end
        end

        START: begin
          if (tick_cnt_q == MID_START) begin
            tick_cnt_d = '0;
            state_d    = rs_q ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        DATA: begin
          if (tick_cnt_q == FULL_BIT) begin
            tick_cnt_d         = '0;
            shift_d[bit_cnt_q] = rs_q;
            bit_cnt_d          = bit_cnt_q + 4'd1;
            if (bit_cnt_q == nbits_q - 4'd1) begin
              state_d = par_en_q ? PARITY : STOP;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        PARITY: begin
          if (tick_cnt_q == FULL_BIT) begin
            tick_cnt_d = '0;
            // Unused high bits of shift_q are zero, so they do not disturb
            // the reduction.
            frame_perr_d = par_odd_q ? ~((^shift_q) ^ rs_q) : ((^shift_q) ^ rs_q);
            state_d      = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        STOP: begin
          if (tick_cnt_q == FULL_BIT) begin
            tick_cnt_d = '0;
            state_d    = IDLE;
            if (!vld_q || rdy) begin
              vld_d        = 1'b1;
              data_d       = shift_q;
              parity_err_d = frame_perr_q;
              frame_err_d  = ~rs_q;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end

        default: state_d = IDLE;
      endcase
    end
  end

  // Frame FSM, datapath and holding-register flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      tick_cnt_q   <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      nbits_q      <= 4'd5;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      frame_perr_q <= 1'b0;
      vld_q        <= 1'b0;
      data_q       <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      nbits_q      <= nbits_d;
      par_en_q     <= par_en_d;
      par_odd_q    <= par_odd_d;
      frame_perr_q <= frame_perr_d;
      vld_q        <= vld_d;
      data_q       <= data_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign vld        = vld_q;
  assign data       = data_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives ideal serial frames at 16 ticks per bit
// with a baud tick every 4 clocks and checks delivered frames, flags,
// handshake, overrun, false-start rejection and mid-frame reset.
module tb_uart_rx;

  localparam int OS = 16;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       baud_tick;
  logic       rx = 1'b1;
  logic [3:0] cfg_nbits = 4'd8;
  logic       cfg_parity_en = 1'b0;
  logic       cfg_parity_odd = 1'b0;
  logic       rdy = 1'b1;
  logic       vld;
  logic [8:0] data;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int checks = 0;
  int errors = 0;

  uart_rx #(.OVERSAMPLE(OS), .DATA_W(9)) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .baud_tick     (baud_tick),
    .rx            (rx),
    .cfg_nbits     (cfg_nbits),
    .cfg_parity_en (cfg_parity_en),
    .cfg_parity_odd(cfg_parity_odd),
    .rdy           (rdy),
    .vld           (vld),
    .data          (data),
    .parity_err    (parity_err),
    .frame_err     (frame_err),
    .overrun       (overrun),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Baud tick: one cycle in every four.
  logic [1:0] div = 2'd0;
  always @(posedge clk) div <= div + 2'd1;
  assign baud_tick = (div == 2'd3);

  // Monitor: counts ticks, accepted frames and overrun pulses, and records
  // which tick the most recent vld rise followed.
  int         tick_num = 0;
  logic       tick_at_edge = 1'b0;
  logic       vld_prev = 1'b0;
  int         frames = 0;
  int         ovr_cnt = 0;
  int         rise_tick = -1;
  logic       rise_on_tick = 1'b0;
  logic [8:0] got_data = '0;
  logic       got_pe = 1'b0;
  logic       got_fe = 1'b0;

  always @(posedge clk) begin
    if (vld && !vld_prev) begin
      rise_tick    <= tick_num;
      rise_on_tick <= tick_at_edge;
    end
    if (vld && rdy) begin
      frames   <= frames + 1;
      got_data <= data;
      got_pe   <= parity_err;
      got_fe   <= frame_err;
    end
    if (overrun) ovr_cnt <= ovr_cnt + 1;
    vld_prev     <= vld;
    tick_at_edge <= baud_tick;
    if (baud_tick) tick_num <= tick_num + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for n baud ticks, returning on the falling edge after the last one.
  task automatic wait_ticks(input int n);
    int k = 0;
    while (k < n) begin
      @(posedge clk);
      if (baud_tick) k++;
    end
    @(negedge clk);
  endtask

  // Sends one frame; e returns the tick after which the start bit began.
  task automatic send(input logic [8:0] d, input int n, input logic pen,
                      input logic pbit, input logic stop, output int e);
    rx = 1'b0;
    e  = tick_num;
    wait_ticks(OS);
    for (int i = 0; i < n; i++) begin
      rx = d[i];
      wait_ticks(OS);
    end
    if (pen) begin
      rx = pbit;
      wait_ticks(OS);
    end
    rx = stop;
    wait_ticks(OS);
    rx = 1'b1;
  endtask

  initial begin
    int e;
    int f0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_vld", vld, 0);
    check("rst_data", data, 0);
    check("rst_perr", parity_err, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovr", overrun, 0);
    check("rst_busy", busy, 0);
    reset_n = 1'b1;
    wait_ticks(3);

    // 8N1 0xA5: stop sampled on tick e+9+16*9, vld rises the next clock.
    cfg_nbits = 4'd8; cfg_parity_en = 1'b0; rdy = 1'b1;
    f0 = frames;
    send(9'h0A5, 8, 1'b0, 1'b0, 1'b1, e);
    wait_ticks(2);
    check("a5_frames", frames, f0 + 1);
    check("a5_data", got_data, 9'h0A5);
    check("a5_perr", got_pe, 0);
    check("a5_ferr", got_fe, 0);
    check("a5_lat_tick", rise_tick, e + 9 + OS * 9);
    check("a5_lat_edge", rise_on_tick, 1);
    check("a5_vld_pulse", vld, 0);

    // 9-bit odd parity 0x1FF: nine ones, so odd parity needs parity bit 0;
    // parity bit 1 makes the total even and is an error.
    cfg_nbits = 4'd9; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b1;
    send(9'h1FF, 9, 1'b1, 1'b0, 1'b1, e);
    wait_ticks(2);
    check("p9_data", got_data, 9'h1FF);
    check("p9_perr_ok", got_pe, 0);
    send(9'h1FF, 9, 1'b1, 1'b1, 1'b1, e);
    wait_ticks(2);
    check("p9_data2", got_data, 9'h1FF);
    check("p9_perr_bad", got_pe, 1);

    // 7-bit even parity 0x41 with low stop, then 0x42 with a good stop.
    cfg_nbits = 4'd7; cfg_parity_en = 1'b1; cfg_parity_odd = 1'b0;
    f0 = frames;
    send(9'h041, 7, 1'b1, 1'b0, 1'b0, e);
    wait_ticks(20);
    check("fe_frames", frames, f0 + 1);
    check("fe_data", got_data, 9'h041);
    check("fe_ferr", got_fe, 1);
    check("fe_perr", got_pe, 0);
    check("fe_idle", busy, 0);
    send(9'h042, 7, 1'b1, 1'b0, 1'b1, e);
    wait_ticks(2);
    check("fe2_data", got_data, 9'h042);
    check("fe2_ferr", got_fe, 0);
    check("fe2_frames", frames, f0 + 2);

    // Overrun: rdy low, back-to-back 0x11 and 0x22.
    cfg_nbits = 4'd8; cfg_parity_en = 1'b0;
    rdy = 1'b0;
    f0 = frames;
    send(9'h011, 8, 1'b0, 1'b0, 1'b1, e);
    send(9'h022, 8, 1'b0, 1'b0, 1'b1, e);
    wait_ticks(2);
    check("ov_vld", vld, 1);
    check("ov_data", data, 9'h011);
    check("ov_pulses", ovr_cnt, 1);
    check("ov_no_accept", frames, f0);
    rdy = 1'b1;
    repeat (3) @(negedge clk);
    check("ov_vld_drop", vld, 0);
    check("ov_accepted", frames, f0 + 1);
    check("ov_acc_data", got_data, 9'h011);
    check("ov_data_hold", data, 9'h011);
    wait_ticks(OS * 12);
    check("ov_no_22", frames, f0 + 1);

    // False start: 5 low ticks, then high.
    f0 = frames;
    rx = 1'b0;
    wait_ticks(5);
    rx = 1'b1;
    wait_ticks(2);
    check("gl_busy", busy, 1);
    wait_ticks(6);
    check("gl_idle", busy, 0);
    check("gl_no_vld", vld, 0);
    check("gl_frames", frames, f0);
    send(9'h03C, 8, 1'b0, 1'b0, 1'b1, e);
    wait_ticks(2);
    check("3c_data", got_data, 9'h03C);
    check("3c_frames", frames, f0 + 1);

    // Reset during data bit 4 of 0x77, then 0x5A.
    f0 = frames;
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < 4; i++) begin
      rx = (9'h077 >> i) & 1'b1;
      wait_ticks(OS);
    end
    rx = 1'b1;
    wait_ticks(OS / 2);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check("mr_vld", vld, 0);
    check("mr_data", data, 0);
    check("mr_perr", parity_err, 0);
    check("mr_ferr", frame_err, 0);
    check("mr_ovr", overrun, 0);
    check("mr_busy", busy, 0);
    reset_n = 1'b1;
    wait_ticks(OS * 8);
    check("mr_idle", busy, 0);
    check("mr_no_frame", frames, f0);
    send(9'h05A, 8, 1'b0, 1'b0, 1'b1, e);
    wait_ticks(2);
    check("5a_data", got_data, 9'h05A);
    check("5a_frames", frames, f0 + 1);
    check("5a_ferr", got_fe, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
